// File: rtl/apb_mem_slave_pkg.sv
// Shared types and constants for the APB memory completer.
// Holds the FSM state encoding, the access classification and a lane-merge helper.
`include "apb_arch.svh"

package apb_mem_slave_pkg;

    localparam int WAIT_CYCLES_MAX = 15;
    localparam int CNT_W           = 4;

    // Encoded as plain constants so the state register stays a bare vector.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WAIT  = 3'd1;
    localparam state_t ST_MERGE = 3'd2;
    localparam state_t ST_RDCAP = 3'd3;
    localparam state_t ST_RESP  = 3'd4;

    typedef enum logic [1:0] {
        ACC_READ    = 2'd0,
        ACC_FULL_WR = 2'd1,
        ACC_ZERO_WR = 2'd2,
        ACC_PART_WR = 2'd3
    } access_t;

    function automatic logic [`DATA_WIDTH-1:0] merge_lanes(
        input logic [`DATA_WIDTH-1:0] wdata,
        input logic [`DATA_WIDTH-1:0] old_data,
        input logic [`STRB_SIZE-1:0]  strobe
    );
        logic [`DATA_WIDTH-1:0] result;
        result = old_data;
        for (int i = 0; i < `STRB_SIZE; i++) begin
            if (strobe[i]) result[8*i +: 8] = wdata[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB completer-side bus bundle: request from the master, response back to it.
`include "apb_arch.svh"

interface apb_mem_slave_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int STRB_SIZE  = `STRB_SIZE
);
    logic                  sel;
    logic                  enable;
    logic                  write;
    logic [STRB_SIZE-1:0]  strobe;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  slverr;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output sel, enable, write, strobe, addr, wdata,
        input  ready, slverr, rdata
    );

    modport slave (
        input  sel, enable, write, strobe, addr, wdata,
        output ready, slverr, rdata
    );
endinterface

// File: rtl/apb_arch.svh
// Bus geometry shared by every APB block in this slice.
// Each width can be overridden from the tool command line.
`ifndef APB_ARCH_SVH
`define APB_ARCH_SVH

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifndef STRB_SIZE
`define STRB_SIZE 4
`endif

`endif

// File: rtl/apb_strb_merge.sv
// Per-byte select between new write data and the word read back from memory.
`include "apb_arch.svh"

module apb_strb_merge #(
    parameter int STRB_SIZE = `STRB_SIZE
) (
    input  logic [STRB_SIZE-1:0]   strobe,
    input  logic [STRB_SIZE*8-1:0] wdata,
    input  logic [STRB_SIZE*8-1:0] data_out,
    output logic [STRB_SIZE*8-1:0] merged
);
    for (genvar i = 0; i < STRB_SIZE; i++) begin : g_lane
        assign merged[8*i +: 8] = strobe[i] ? wdata[8*i +: 8] : data_out[8*i +: 8];
    end
endmodule

// File: rtl/apb_mem_slave.sv
// APB completer in front of a single-port synchronous word memory with 1-cycle read latency.
// Partial-strobe writes become a read-modify-write because the memory has no byte enables.
`include "apb_arch.svh"

module apb_mem_slave
    import apb_mem_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int STRB_SIZE   = `STRB_SIZE,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    apb_mem_slave_if.slave               bus,
    output logic                         wr,
    output logic [$clog2(MEM_DEPTH)-1:0] address,
    output logic [DATA_WIDTH-1:0]        data_in,
    input  logic [DATA_WIDTH-1:0]        data_out
);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [MEM_AW-1:0]     word_q;
    access_t               access_q;
    access_t               access_d;
    logic [STRB_SIZE-1:0]  strobe_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] merged;
    logic                  err_q;
    logic                  setup;
    logic                  addr_err;
    logic                  at_issue;

    assign setup    = bus.sel && !bus.enable;
    assign addr_err = (bus.addr[1:0] != 2'b00) || (bus.addr[ADDR_WIDTH-1:2] >= DEPTH_WORDS);
    assign at_issue = (state == ST_WAIT) && (cnt == '0) && bus.sel;

    always_comb begin
        access_d = ACC_READ;
        if (bus.write) begin
            if (&bus.strobe)          access_d = ACC_FULL_WR;
            else if (bus.strobe == '0) access_d = ACC_ZERO_WR;
            else                       access_d = ACC_PART_WR;
        end
    end

    apb_strb_merge #(
        .STRB_SIZE (STRB_SIZE)
    ) u_merge (
        .strobe   (strobe_q),
        .wdata    (wdata_q),
        .data_out (data_out),
        .merged   (merged)
    );

    // Dropping sel after the setup phase abandons the transfer without a response.
    always_comb begin
        // NOTE: every path must assign state_nxt; the default up front keeps this purely combinational.
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (setup) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.sel)                     state_nxt = ST_IDLE;
                else if (cnt != '0)               state_nxt = ST_WAIT;
                else if (err_q)                   state_nxt = ST_RESP;
                else if (access_q == ACC_READ)    state_nxt = ST_RDCAP;
                else if (access_q == ACC_PART_WR) state_nxt = ST_MERGE;
                else                              state_nxt = ST_RESP;
            end
            ST_MERGE, ST_RDCAP: begin
                state_nxt = bus.sel ? ST_RESP : ST_IDLE;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            word_q   <= '0;
            access_q <= ACC_READ;
            strobe_q <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && setup) begin
                cnt      <= CNT_LOAD;
                word_q   <= bus.addr[MEM_AW+1:2];
                access_q <= access_d;
                strobe_q <= bus.strobe;
                wdata_q  <= bus.wdata;
                err_q    <= addr_err;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == ST_RDCAP && bus.sel) begin
                rdata_q <= data_out;
            end
        end
    end

    // The address is always presented; only wr qualifies an actual memory write.
    assign address = word_q;
    assign wr      = (at_issue && !err_q && access_q == ACC_FULL_WR) ||
                     (state == ST_MERGE && bus.sel);

    always_comb begin
        data_in = '0;
        if (state == ST_MERGE) begin
            data_in = merged;
        end else if (state == ST_WAIT && access_q == ACC_FULL_WR) begin
            data_in = wdata_q;
        end
    end

    assign bus.ready  = (state == ST_RESP);
    assign bus.slverr = (state == ST_RESP) && err_q;
    assign bus.rdata  = (state == ST_RESP && !err_q && access_q == ACC_READ) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed and randomized checks of apb_mem_slave against a word-array reference model.
// Three instances cover WAIT_CYCLES of 0, 3 and 2, each with its own memory model.
module tb_apb_mem_slave;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel_d     [3];
    logic        en_d      [3];
    logic        write_d   [3];
    logic [3:0]  strb_d    [3];
    logic [31:0] addr_d    [3];
    logic [31:0] wdata_d   [3];
    logic        ready_o   [3];
    logic        slverr_o  [3];
    logic [31:0] rdata_o   [3];
    logic        wr_o      [3];
    logic [7:0]  address_o [3];
    logic [31:0] data_in_o [3];

    logic [31:0] ref_mem [3][256];
    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WCG = (g == 1) ? 3 : (g == 2) ? 2 : 0;
        logic [31:0] mem [256];
        logic [31:0] mem_q;

        apb_mem_slave_if bus ();
        assign bus.sel    = sel_d[g];
        assign bus.enable = en_d[g];
        assign bus.write  = write_d[g];
        assign bus.strobe = strb_d[g];
        assign bus.addr   = addr_d[g];
        assign bus.wdata  = wdata_d[g];
        assign ready_o[g]  = bus.ready;
        assign slverr_o[g] = bus.slverr;
        assign rdata_o[g]  = bus.rdata;

        apb_mem_slave #(
            .MEM_DEPTH   (256),
            .WAIT_CYCLES (WCG)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .bus      (bus),
            .wr       (wr_o[g]),
            .address  (address_o[g]),
            .data_in  (data_in_o[g]),
            .data_out (mem_q)
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = '0;
        end

        always @(posedge clk) begin
            if (wr_o[g]) mem[address_o[g]] <= data_in_o[g];
            mem_q <= mem[address_o[g]];
        end
    end

    function automatic int wc(input int d);
        return (d == 1) ? 3 : (d == 2) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input int d, input string tag);
        check($sformatf("%s dut%0d ready", tag, d),   32'(ready_o[d]),   32'd0);
        check($sformatf("%s dut%0d slverr", tag, d),  32'(slverr_o[d]),  32'd0);
        check($sformatf("%s dut%0d rdata", tag, d),   rdata_o[d],        32'd0);
        check($sformatf("%s dut%0d wr", tag, d),      32'(wr_o[d]),      32'd0);
        check($sformatf("%s dut%0d address", tag, d), 32'(address_o[d]), 32'd0);
        check($sformatf("%s dut%0d data_in", tag, d), data_in_o[d],      32'd0);
    endtask

    task automatic bus_idle(input int d);
        @(posedge clk); #1;
        sel_d[d] = 1'b0;
        en_d[d]  = 1'b0;
    endtask

    // One complete APB transfer; expectations come only from the reference memory and the rules.
    task automatic xfer(input int d, input bit is_wr, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd, output logic [31:0] rd_out);
        logic [31:0] w;
        logic [31:0] old_word, new_word, exp_rd, rd, wr_word;
        logic [7:0]  wr_addr;
        logic        slv;
        bit          exp_err, exp_wr, got;
        int          exp_lat, lat, wr_cnt;
        string       tag;

        tag      = $sformatf("dut%0d %s@%08h", d, is_wr ? "wr" : "rd", a);
        w        = a / 4;
        exp_err  = (a % 4 != 0) || (w >= 256);
        old_word = exp_err ? 32'd0 : ref_mem[d][w[7:0]];
        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) new_word[8*i +: 8] = wd[8*i +: 8];
        end
        exp_wr  = is_wr && !exp_err && (s != 4'h0);
        exp_rd  = (!is_wr && !exp_err) ? old_word : 32'd0;
        exp_lat = wc(d) + ((exp_err || (is_wr && (s == 4'hF || s == 4'h0))) ? 2 : 3);

        @(posedge clk); #1;
        sel_d[d]   = 1'b1;
        en_d[d]    = 1'b0;
        write_d[d] = is_wr;
        strb_d[d]  = s;
        addr_d[d]  = a;
        wdata_d[d] = wd;

        got = 1'b0; lat = -1; wr_cnt = 0; slv = 1'b0; rd = '0; wr_word = '0; wr_addr = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (wr_o[d]) begin
                wr_cnt++;
                wr_addr = address_o[d];
                wr_word = data_in_o[d];
            end
            if (ready_o[d]) begin
                got = 1'b1;
                lat = c;
                slv = slverr_o[d];
                rd  = rdata_o[d];
            end else begin
                // Access-phase inputs are scrambled; the completer must use its latched copy.
                @(posedge clk); #1;
                en_d[d]    = 1'b1;
                addr_d[d]  = $urandom;
                wdata_d[d] = $urandom;
                strb_d[d]  = 4'($urandom);
                write_d[d] = 1'($urandom);
            end
        end

        check({tag, " ready"},   32'(got),    32'd1);
        check({tag, " latency"}, 32'(lat),    32'(exp_lat));
        check({tag, " slverr"},  32'(slv),    32'(exp_err));
        check({tag, " rdata"},   rd,          exp_rd);
        check({tag, " wr_cnt"},  32'(wr_cnt), exp_wr ? 32'd1 : 32'd0);
        if (exp_wr && wr_cnt == 1) begin
            check({tag, " address"}, 32'(wr_addr), 32'(w[7:0]));
            check({tag, " data_in"}, wr_word,      new_word);
            ref_mem[d][w[7:0]] = new_word;
        end
        rd_out = rd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        for (int d = 0; d < 3; d++) begin
            sel_d[d] = 1'b0; en_d[d] = 1'b0; write_d[d] = 1'b0;
            strb_d[d] = '0; addr_d[d] = '0; wdata_d[d] = '0;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = '0;
        end

        #12;
        for (int d = 0; d < 3; d++) check_quiet(d, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full write then read back.
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd);
        bus_idle(0);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, rd);
        check("t1 readback", rd, 32'hDEADBEEF);
        bus_idle(0);

        // Partial-strobe read-modify-write.
        xfer(0, 1'b1, 32'h10, 4'hF, 32'h11223344, rd);
        bus_idle(0);
        xfer(0, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD, rd);
        bus_idle(0);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, rd);
        check("t2 merged readback", rd, 32'h11BB33DD);
        bus_idle(0);

        // Error responses.
        xfer(0, 1'b0, 32'h402, 4'h0, 32'h0, rd);
        bus_idle(0);
        xfer(0, 1'b0, 32'h400, 4'h0, 32'h0, rd);
        bus_idle(0);
        xfer(0, 1'b1, 32'h13, 4'hF, 32'h5A5A5A5A, rd);
        bus_idle(0);
        xfer(0, 1'b1, 32'h3FC, 4'hF, 32'h0BADF00D, rd);
        bus_idle(0);
        xfer(0, 1'b1, 32'h24, 4'h0, 32'hFFFFFFFF, rd);
        bus_idle(0);

        // Wait states with a back-to-back follow-on.
        xfer(1, 1'b0, 32'h0, 4'h0, 32'h0, rd);
        xfer(1, 1'b1, 32'h4, 4'hF, 32'h01020304, rd);
        bus_idle(1);
        xfer(1, 1'b0, 32'h4, 4'h0, 32'h0, rd);
        check("t4 readback", rd, 32'h01020304);
        bus_idle(1);

        // Reset asserted during MERGE of a partial write.
        xfer(0, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, rd);
        bus_idle(0);
        @(posedge clk); #1;
        sel_d[0] = 1'b1; en_d[0] = 1'b0; write_d[0] = 1'b1;
        strb_d[0] = 4'b0011; addr_d[0] = 32'h20; wdata_d[0] = 32'h12345678;
        @(posedge clk); #1;
        en_d[0] = 1'b1;
        @(posedge clk); #2;
        check("t5 merge wr", 32'(wr_o[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet(0, "t5 midreset");
        sel_d[0] = 1'b0; en_d[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, rd);
        check("t5 old value", rd, 32'hCAFEF00D);
        bus_idle(0);

        // Abort in WAIT, then an immediate setup proves the FSM is back in IDLE.
        @(posedge clk); #1;
        sel_d[2] = 1'b1; en_d[2] = 1'b0; write_d[2] = 1'b1;
        strb_d[2] = 4'hF; addr_d[2] = 32'h8; wdata_d[2] = 32'h55AA55AA;
        @(posedge clk); #1;
        sel_d[2] = 1'b0;
        @(negedge clk);
        check("t6 abort wr", 32'(wr_o[2]), 32'd0);
        check("t6 abort ready", 32'(ready_o[2]), 32'd0);
        xfer(2, 1'b0, 32'h8, 4'h0, 32'h0, rd);
        check("t6 not written", rd, 32'h0);
        bus_idle(2);

        // Randomized mix over a small window so reads revisit written words.
        for (int k = 0; k < 90; k++) begin
            int          d;
            int          r;
            logic [31:0] a;
            d = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 63)) * 4;
            else             a = 32'($urandom_range(0, 15)) * 4;
            xfer(d, 1'($urandom), a, 4'($urandom), $urandom, rd);
            if ($urandom_range(0, 3) != 0) bus_idle(d);
        end
        for (int d = 0; d < 3; d++) bus_idle(d);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB completer stage directly downstream of the APB master. Consumes sel/enable/write/strobe/addr/wdata and returns ready/slverr/rdata.
- Drives a single-port synchronous word memory (wr/address/data_in/data_out) with 1-cycle read latency.
- The memory has no byte enables, so partial-strobe writes are done as an internal read-modify-write.
- Adds programmable wait states and error responses for out-of-range or misaligned addresses.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (32): APB byte-address width.
- DATA_WIDTH, `DATA_WIDTH (32): data width; must be 32.
- STRB_SIZE, `STRB_SIZE (4): byte lanes, DATA_WIDTH/8.
- MEM_DEPTH, 256: memory words; MEM_AW = $clog2(MEM_DEPTH).
- WAIT_CYCLES, 0: extra wait states inserted before memory access (0..15).

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- sel, in, 1: APB select.
- enable, in, 1: APB enable (access phase).
- write, in, 1: 1 = write, 0 = read.
- strobe, in, STRB_SIZE: write byte lanes.
- addr, in, ADDR_WIDTH: byte address.
- wdata, in, DATA_WIDTH: write data.
- ready, out, 1: transfer complete.
- slverr, out, 1: error response, valid with ready.
- rdata, out, DATA_WIDTH: read data, valid with ready.
- wr, out, 1: memory write enable.
- address, out, MEM_AW: memory word address.
- data_in, out, DATA_WIDTH: memory write data.
- data_out, in, DATA_WIDTH: memory read data, valid the cycle after the address is presented with wr=0.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; wait counter 0; latches 0.
  - ready=0, slverr=0, rdata=0, wr=0, address=0, data_in=0.
- Latching: in IDLE, sel=1 && enable=0 (setup phase) latches addr, write, strobe and wdata, and loads cnt=WAIT_CYCLES. Next state is WAIT.
- err decode, computed at latch: latched addr[1:0]!=0, or addr[ADDR_WIDTH-1:2] >= MEM_DEPTH.
- WAIT:
  - If cnt!=0, decrement cnt and stay.
  - If cnt==0:
    - err: go to RESP with slverr; no memory access.
    - Write with strobe all-ones: wr=1, address=addr[MEM_AW+1:2], data_in=wdata this cycle; go to RESP.
    - Write with strobe==0: no memory write, no error; go to RESP.
    - Partial-strobe write: present the address with wr=0; go to MERGE.
    - Read: present the address with wr=0; go to RDCAP.
- MERGE: data_in = per lane i, strobe[i] ? wdata byte i : data_out byte i. wr=1 at the same address; go to RESP.
- RDCAP: register data_out into the rdata hold register; go to RESP.
- RESP:
  - ready=1 for exactly one cycle.
  - slverr = err.
  - rdata = captured word for a successful read, else 0.
  - Next state IDLE. A back-to-back setup is accepted in the following IDLE cycle.
- Outputs outside RESP: ready=0, slverr=0, rdata=0.
- wr is asserted only in WAIT (full write) or MERGE. It is 0 in every other state.
- Latency with WAIT_CYCLES=N, counted from the setup cycle T0 to the ready cycle:
  - error or full/zero-strobe write: T0+2+N;
  - read or partial write: T0+3+N.
- Abort: sel=0 in WAIT/MERGE/RDCAP (protocol violation):
  - return to IDLE immediately with no ready pulse;
  - a write not yet issued is dropped.
- Inputs changing during the access phase are ignored; the latched values are used.
- Read strobe is ignored.
- Reset mid-transfer: immediate return to reset values; the memory is not written in that cycle.

Decomposition:
- apb_mem_slave_pkg holds:
  - the state enum (IDLE, WAIT, MERGE, RDCAP, RESP);
  - the WAIT_CYCLES max constant;
  - the lane-merge function prototype.
- Field widths come from the `ADDR_WIDTH/`DATA_WIDTH/`STRB_SIZE macros in apb_arch.svh.
- Sub-module apb_strb_merge: combinational per-byte mux of wdata and data_out under strobe, parameterised by STRB_SIZE.

Test Plan:
1. WAIT_CYCLES=0; write addr 0x10, strobe 4'hF, wdata 0xDEADBEEF. Then read 0x10 → ready at T0+2 for the write with wr=1 and address=4; the read gives ready at T0+3 with rdata=0xDEADBEEF, slverr=0.
2. Mem[4]=0x11223344; write addr 0x10, strobe 4'b0101, wdata 0xAABBCCDD → one read cycle, then wr=1 with data_in=0x11BB33DD; a subsequent read returns 0x11BB33DD.
3. Read addr 0x402 (misaligned) and addr 0x400 (MEM_DEPTH=256, out of range) → ready with slverr=1, rdata=0, wr never asserted.
4. WAIT_CYCLES=3; read addr 0x0 → ready exactly at T0+6. A back-to-back write to 0x4 is accepted at the next setup cycle and completes at its own T0+5.
5. Assert rst_n=0 during MERGE of a partial write → all outputs 0 at once, memory unchanged. After release, a read of the same address returns the old value.
6. Drop sel in WAIT of a full write (WAIT_CYCLES=2) → no ready pulse, wr stays 0, FSM in IDLE the next cycle.
